// File: rtl/motor_mixer_pipelined.sv
// Quad-X motor mixer: 3-stage mix/clamp pipeline,
// arm/ramp state machine and input-loss watchdog.
module motor_mixer_pipelined #(
  parameter int BIT_WIDTH            = 16,
  parameter int MOTOR_RATE_BIT_WIDTH = 16,
  parameter int AXIS_SHIFT           = 1,
  parameter int MOTOR_MIN            = 0,
  parameter int MOTOR_MAX            = 2**MOTOR_RATE_BIT_WIDTH-1,
  parameter int RAMP_STEP            = 4096,
  parameter int TIMEOUT_CYCLES       = 1000
) (
  input  logic                              sys_clk,
  input  logic                              rst_n,
  input  logic                              arm,
  input  logic                              in_valid,
  input  logic [BIT_WIDTH-1:0]              throttle_rate,
  input  logic [BIT_WIDTH-1:0]              yaw_rate,
  input  logic [BIT_WIDTH-1:0]              roll_rate,
  input  logic [BIT_WIDTH-1:0]              pitch_rate,
  output logic [4*MOTOR_RATE_BIT_WIDTH-1:0] motor_rates,
  output logic                              out_valid,
  output logic [1:0]                        mixer_state
);

  localparam int MW  = MOTOR_RATE_BIT_WIDTH;
  localparam int XW  = BIT_WIDTH + 3;
  localparam int CW  = ((XW > MW + 1) ? XW : MW + 1) + 1;
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [MW-1:0]        M_MAX = MW'(MOTOR_MAX);
  localparam logic [MW-1:0]        M_MIN = MW'(MOTOR_MIN);
  localparam logic signed [CW-1:0] MINX  = CW'(MOTOR_MIN);
  localparam logic [MW:0]          STEP  = (MW+1)'(RAMP_STEP);
  localparam logic [WDW-1:0]       TO_V  = WDW'(TIMEOUT_CYCLES);
  localparam logic [WDW-1:0]       TO_M1 = WDW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMING   = 2'd1,
    ARMED    = 2'd2,
    FAILSAFE = 2'd3
  } state_t;

  state_t         state;
  logic [MW-1:0]  ramp;
  logic [WDW-1:0] wd;

  logic [MW:0]   ramp_sum;
  logic [MW-1:0] ramp_nxt;
  logic          active;
  logic          timeout_hit;

  logic signed [BIT_WIDTH-1:0] ys, rs, ps;
  logic signed [XW-1:0] t1, y1, r1, p1;
  logic signed [XW-1:0] m0, m1, m2, m3;
  logic                 v1, v2;

  logic [MW-1:0] ceil;
  logic          zero_out;

  // Ramp step and watchdog threshold decode
  always_comb begin
    ramp_sum    = {1'b0, ramp} + STEP;
    ramp_nxt    = (ramp_sum >= {1'b0, M_MAX}) ? M_MAX : ramp_sum[MW-1:0];
    active      = (state == ARMING) || (state == ARMED);
    timeout_hit = active && !in_valid && (wd >= TO_M1);
  end

  // Arm / ramp / failsafe state machine
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DISARMED;
      ramp  <= '0;
    end else begin
      unique case (state)
        DISARMED: begin
          if (arm) begin
            state <= ARMING;
            ramp  <= '0;
          end
        end
        ARMING: begin
          if (!arm) state <= DISARMED;
          else if (timeout_hit) state <= FAILSAFE;
          else begin
            ramp <= ramp_nxt;
            if (ramp_nxt == M_MAX) state <= ARMED;
          end
        end
        ARMED: begin
          if (!arm) state <= DISARMED;
          else if (timeout_hit) state <= FAILSAFE;
        end
        FAILSAFE: begin
          if (!arm) state <= DISARMED;
        end
      endcase
    end
  end

  assign mixer_state = state;

  // Input-loss watchdog, saturating at the timeout
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) wd <= '0;
    else if (in_valid || !active) wd <= '0;
    else if (wd < TO_V) wd <= wd + 1'b1;
  end

  // S1 input scaling
  always_comb begin
    ys = $signed(yaw_rate) >>> AXIS_SHIFT;
    rs = $signed(roll_rate) >>> AXIS_SHIFT;
    ps = $signed(pitch_rate) >>> AXIS_SHIFT;
  end

  // S1 register: zero-extended throttle, sign-extended axes
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      t1 <= '0;
      y1 <= '0;
      r1 <= '0;
      p1 <= '0;
    end else begin
      v1 <= in_valid;
      t1 <= $signed({3'b000, throttle_rate});
      y1 <= $signed({{3{ys[BIT_WIDTH-1]}}, ys});
      r1 <= $signed({{3{rs[BIT_WIDTH-1]}}, rs});
      p1 <= $signed({{3{ps[BIT_WIDTH-1]}}, ps});
    end
  end

  // S2 quad-X mixing
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      v2 <= 1'b0;
      m0 <= '0;
      m1 <= '0;
      m2 <= '0;
      m3 <= '0;
    end else begin
      v2 <= v1;
      m0 <= t1 + p1 + r1 - y1;
      m1 <= t1 + p1 - r1 + y1;
      m2 <= t1 - p1 - r1 - y1;
      m3 <= t1 - p1 + r1 + y1;
    end
  end

  // Clamp ceiling from the state at the S3 edge
  always_comb begin
    ceil     = '0;
    zero_out = 1'b1;
    unique case (state)
      ARMED: begin
        ceil     = M_MAX;
        zero_out = 1'b0;
      end
      ARMING: begin
        ceil     = (ramp < M_MAX) ? ramp : M_MAX;
        zero_out = 1'b0;
      end
      DISARMED, FAILSAFE: begin
        ceil     = '0;
        zero_out = 1'b1;
      end
    endcase
  end

  function automatic logic [MW-1:0] clamp(
    input logic signed [XW-1:0] v,
    input logic [MW-1:0]        hi,
    input logic                 z
  );
    logic signed [CW-1:0] vx;
    logic signed [CW-1:0] hx;
    vx = $signed({{(CW-XW){v[XW-1]}}, v});
    hx = $signed({{(CW-MW){1'b0}}, hi});
    if (z) clamp = '0;
    else if (vx < MINX) clamp = M_MIN;
    else if (vx > hx) clamp = hi;
    else clamp = vx[MW-1:0];
  endfunction

  // S3 clamp and output register; holds when no sample exits
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      motor_rates <= '0;
    end else begin
      out_valid <= v2;
      if (v2) begin
        motor_rates <= {clamp(m3, ceil, zero_out),
                        clamp(m2, ceil, zero_out),
                        clamp(m1, ceil, zero_out),
                        clamp(m0, ceil, zero_out)};
      end
    end
  end

endmodule

// File: tb/tb_motor_mixer_pipelined.sv
// Randomised scoreboard bench for motor_mixer_pipelined
// against a cycle-level behavioural reference.
module tb_motor_mixer_pipelined;

  localparam int BW   = 16;
  localparam int MW   = 16;
  localparam int MAXV = 65535;
  localparam int STEP = 4096;
  localparam int TO   = 1000;

  logic          sys_clk = 1'b0;
  logic          rst_n   = 1'b0;
  logic          arm     = 1'b0;
  logic          in_valid = 1'b0;
  logic [BW-1:0] throttle_rate = '0;
  logic [BW-1:0] yaw_rate = '0;
  logic [BW-1:0] roll_rate = '0;
  logic [BW-1:0] pitch_rate = '0;
  logic [4*MW-1:0] motor_rates;
  logic          out_valid;
  logic [1:0]    mixer_state;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int m[4];
  } mix_t;

  mix_t sb[$];

  int m_st, m_ramp, m_idle;
  int edge_st, edge_ramp;
  bit d1, d2, exp_ov;
  int exp_m[4];

  motor_mixer_pipelined dut (
    .sys_clk       (sys_clk),
    .rst_n         (rst_n),
    .arm           (arm),
    .in_valid      (in_valid),
    .throttle_rate (throttle_rate),
    .yaw_rate      (yaw_rate),
    .roll_rate     (roll_rate),
    .pitch_rate    (pitch_rate),
    .motor_rates   (motor_rates),
    .out_valid     (out_valid),
    .mixer_state   (mixer_state)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int axis(input logic [BW-1:0] v);
    logic signed [BW-1:0] s;
    s = v;
    return int'(s) >>> 1;
  endfunction

  // Reference model: spec rules applied once per clock
  always @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = 0;
      m_ramp = 0;
      m_idle = 0;
      d1 = 0;
      d2 = 0;
      exp_ov = 0;
      edge_st = 0;
      edge_ramp = 0;
      sb.delete();
      for (int i = 0; i < 4; i++) exp_m[i] = 0;
    end else begin
      bit act, tmo;
      int nidle;
      mix_t e;
      int t, y, r, p;
      edge_st = m_st;
      edge_ramp = m_ramp;
      exp_ov = d2;
      d2 = d1;
      d1 = in_valid;
      if (in_valid) begin
        t = int'(throttle_rate);
        y = axis(yaw_rate);
        r = axis(roll_rate);
        p = axis(pitch_rate);
        e.m[0] = t + p + r - y;
        e.m[1] = t + p - r + y;
        e.m[2] = t - p - r - y;
        e.m[3] = t - p + r + y;
        sb.push_back(e);
      end
      act = (m_st == 1) || (m_st == 2);
      tmo = act && !in_valid && (m_idle + 1 >= TO);
      nidle = (in_valid || !act) ? 0 : ((m_idle < TO) ? m_idle + 1 : TO);
      if (m_st == 0) begin
        if (arm) begin
          m_st = 1;
          m_ramp = 0;
        end
      end else if (m_st == 3) begin
        if (!arm) m_st = 0;
      end else if (!arm) m_st = 0;
      else if (tmo) m_st = 3;
      else if (m_st == 1) begin
        m_ramp = (m_ramp + STEP > MAXV) ? MAXV : m_ramp + STEP;
        if (m_ramp == MAXV) m_st = 2;
      end
      m_idle = nidle;
    end
  end

  // Monitor: compares state, valid and motor rates mid-cycle
  always @(negedge sys_clk) begin
    if (!rst_n) begin
      chk("rst_state", int'(mixer_state), 0);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_motors", (motor_rates == '0) ? 1 : 0, 1);
    end else begin
      chk("state", int'(mixer_state), m_st);
      chk("out_valid", int'(out_valid), int'(exp_ov));
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("sb_empty", 1, 0);
        end else begin
          mix_t e;
          int hi;
          e = sb.pop_front();
          hi = (edge_st == 2) ? MAXV : ((edge_ramp < MAXV) ? edge_ramp : MAXV);
          for (int i = 0; i < 4; i++) begin
            if (edge_st == 0 || edge_st == 3) exp_m[i] = 0;
            else if (e.m[i] < 0) exp_m[i] = 0;
            else if (e.m[i] > hi) exp_m[i] = hi;
            else exp_m[i] = e.m[i];
          end
        end
      end
      for (int i = 0; i < 4; i++)
        chk($sformatf("m%0d", i), int'(motor_rates[i*MW +: MW]), exp_m[i]);
    end
  end

  task automatic step(input bit a, input bit v,
                      input int t, input int y, input int r, input int p);
    arm = a;
    in_valid = v;
    throttle_rate = t[BW-1:0];
    yaw_rate = y[BW-1:0];
    roll_rate = r[BW-1:0];
    pitch_rate = p[BW-1:0];
    @(negedge sys_clk);
  endtask

  task automatic idle(input bit a, input int n);
    for (int i = 0; i < n; i++) step(a, 0, 0, 0, 0, 0);
  endtask

  task automatic wait_state(input int s, input int budget);
    int n;
    n = 0;
    while (int'(mixer_state) != s && n < budget) begin
      step(1, 1, 0, 0, 0, 0);
      n++;
    end
    chk("wait_state", int'(mixer_state), s);
  endtask

  task automatic rnd(input bit a);
    step(a, $urandom_range(0, 3) != 0,
         int'($urandom & 32'hffff), int'($urandom & 32'hffff),
         int'($urandom & 32'hffff), int'($urandom & 32'hffff));
  endtask

  initial begin
    bit a;
    @(negedge sys_clk);
    @(negedge sys_clk);
    #1 rst_n = 1'b1;
    @(negedge sys_clk);

    // disarmed sample -> zeros
    step(0, 1, 1000, 0, 0, 0);
    idle(0, 4);

    // arm, ramp to armed, then basic mixes
    step(1, 0, 0, 0, 0, 0);
    wait_state(2, 40);
    step(1, 1, 1000, 0, 0, 200);
    step(1, 1, 100, -400, 0, 0);
    step(1, 1, 65535, 32767, 32767, 32767);
    step(1, 1, 0, -32768, 32767, -32768);
    step(1, 1, 65535, -32768, -32768, -32768);
    idle(1, 4);

    // random armed traffic
    for (int i = 0; i < 300; i++) rnd(1);

    // ramp-limited outputs during arming
    idle(0, 2);
    step(1, 1, 60000, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 1, 60000, 0, 0, 0);
    chk("armed_after_ramp", int'(mixer_state), 2);

    // watchdog: in_valid exactly at threshold keeps armed
    idle(1, TO - 1);
    step(1, 1, 500, 0, 0, 0);
    chk("wd_rescue", int'(mixer_state), 2);
    idle(1, 3);

    // full timeout -> failsafe, held while armed
    idle(1, TO);
    chk("failsafe", int'(mixer_state), 3);
    step(1, 1, 3000, 10, 20, 30);
    idle(1, 4);
    step(0, 0, 0, 0, 0, 0);
    chk("fs_to_disarm", int'(mixer_state), 0);

    // reset pulse mid-stream drops in-flight samples
    step(1, 1, 100, 0, 0, 0);
    wait_state(2, 40);
    step(1, 1, 1234, 0, 0, 0);
    step(1, 1, 2345, 0, 0, 0);
    #1 rst_n = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    #1 rst_n = 1'b1;
    @(negedge sys_clk);
    chk("post_rst_valid", int'(out_valid), 0);
    idle(0, 4);

    // random mix of arm toggles and traffic
    a = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 59) == 0) a = !a;
      rnd(a);
    end
    idle(0, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
